// File: rtl/mix_columns_engine.sv
// mix_columns_engine: sequential AES (Inv)MixColumns unit.
// A 128-bit state is accepted over valid/ready, LANES columns are transformed
// per RUN cycle with shared xtime logic, and the result is held in DONE until
// the consumer takes it.
module mix_columns_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
            $error("mix_columns_engine: LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int         NSTEP     = 4 / LANES;
    localparam logic [1:0] LAST_STEP = 2'(NSTEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  cnt_r;
    logic        inv_r;
    logic [31:0] src_col_r [4];
    logic [31:0] res_col_r [4];
    logic [31:0] res_col_next_s [4];
    logic [31:0] lane_out_s [LANES];
    logic [1:0]  col_sel_s [LANES];
    logic        accept_s;
    logic        out_valid_r;
    logic        busy_r;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Transform one column (row 0 in the MS byte). Only x2/x4/x8 are built
    // per byte; every coefficient of both matrices is an XOR of those and b.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] p0 [4];
        logic [7:0] p1 [4];
        logic [7:0] p2 [4];
        logic [7:0] p3 [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [31:0] res;
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int j = 0; j < 4; j++) begin
            x2 = xtime(a[j]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (inv) begin
                p0[j] = x8 ^ x4 ^ x2;       // 0e
                p1[j] = x8 ^ x2 ^ a[j];     // 0b
                p2[j] = x8 ^ x4 ^ a[j];     // 0d
                p3[j] = x8 ^ a[j];          // 09
            end else begin
                p0[j] = x2;                 // 02
                p1[j] = x2 ^ a[j];          // 03
                p2[j] = a[j];               // 01
                p3[j] = a[j];               // 01
            end
        end
        // Row r uses coefficient index (j - r) mod 4 on byte j.
        res[31:24] = p0[0] ^ p1[1] ^ p2[2] ^ p3[3];
        res[23:16] = p0[1] ^ p1[2] ^ p2[3] ^ p3[0];
        res[15:8]  = p0[2] ^ p1[3] ^ p2[0] ^ p3[1];
        res[7:0]   = p0[3] ^ p1[0] ^ p2[1] ^ p3[2];
        return res;
    endfunction

    assign in_ready  = (state_r == IDLE) && !rst;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_state = {res_col_r[0], res_col_r[1], res_col_r[2], res_col_r[3]};

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = RUN;
                else          state_next_s = IDLE;
            end
            RUN: begin
                if (cnt_r == LAST_STEP) state_next_s = DONE;
                else                    state_next_s = RUN;
            end
            DONE: begin
                if (out_ready) state_next_s = IDLE;
                else           state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Per-lane column selection and transform for the current step.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            col_sel_s[l]  = 2'(int'(cnt_r) * LANES + l);
            lane_out_s[l] = mix_col(src_col_r[col_sel_s[l]], inv_r);
        end
    end

    // Merge lane results into the columns they belong to this step.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            res_col_next_s[c] = res_col_r[c];
            for (int l = 0; l < LANES; l++) begin
                res_col_next_s[c] = (col_sel_s[l] == 2'(c)) ? lane_out_s[l] : res_col_next_s[c];
            end
        end
    end

    // Operand latch on accept, step counter and result columns during RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 2'd0;
            inv_r <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                src_col_r[c] <= 32'h0;
                res_col_r[c] <= 32'h0;
            end
        end else if (accept_s) begin
            cnt_r        <= 2'd0;
            inv_r        <= in_inv;
            src_col_r[0] <= in_state[127:96];
            src_col_r[1] <= in_state[95:64];
            src_col_r[2] <= in_state[63:32];
            src_col_r[3] <= in_state[31:0];
        end else if (state_r == RUN) begin
            cnt_r <= (cnt_r == LAST_STEP) ? 2'd0 : cnt_r + 2'd1;
            for (int c = 0; c < 4; c++) begin
                res_col_r[c] <= res_col_next_s[c];
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Testbench for mix_columns_engine: three instances (LANES 1, 2, 4), checked
// against a general GF(2^8) matrix-multiply reference model.
module tb_mix_columns_engine;

    logic         clk;
    logic         rst       [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_state  [3];
    logic         in_inv    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_state [3];
    logic         busy      [3];

    int pass_cnt = 0;
    int total_cnt = 0;
    int lanes_of [3] = '{1, 2, 4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        mix_columns_engine #(.LANES(L)) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_state (in_state[g]),
            .in_inv   (in_inv[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_state(out_state[g]),
            .busy     (busy[g])
        );
    end

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Reference: circulant matrix times each column.
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0] cf [4];
        logic [7:0] acc;
        logic [127:0] r;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(cf[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    // One full transaction on unit u; reports result, latency, handshake sanity, timeout.
    task automatic run_txn(input int u, input logic [127:0] st, input logic inv, input int hold,
                           output logic [127:0] res, output int lat, output bit hs_ok, output bit tmo);
        int w;
        hs_ok = 1'b1; tmo = 1'b0; lat = 0; res = '0; w = 0;
        @(negedge clk);
        while (!in_ready[u] && w < 50) begin @(negedge clk); w++; end
        if (!in_ready[u]) begin tmo = 1'b1; return; end
        in_valid[u] = 1'b1; in_state[u] = st; in_inv[u] = inv;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        in_state[u] = {$urandom, $urandom, $urandom, $urandom};
        in_inv[u] = ~inv;
        while (!out_valid[u] && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!out_valid[u]) begin tmo = 1'b1; return; end
        res = out_state[u];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (out_state[u] !== res || out_valid[u] !== 1'b1) hs_ok = 1'b0;
        end
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        out_ready[u] = 1'b0;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) hs_ok = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) rst[u] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            total_cnt++;
            if (out_valid[u] !== 1'b0 || busy[u] !== 1'b0 || out_state[u] !== 128'h0 || in_ready[u] !== 1'b0)
                $display("FAIL reset u%0d: ov=%b busy=%b ir=%b os=%h required 0 0 0 0", u, out_valid[u], busy[u], in_ready[u], out_state[u]);
            else pass_cnt++;
        end
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            total_cnt++;
            if (in_ready[u] !== 1'b1) $display("FAIL reset_release u%0d: in_ready=%b required 1", u, in_ready[u]);
            else pass_cnt++;
        end
    endtask

    // Fixed vector on every unit, checked against a known constant and latency.
    task automatic test_vector(input string name, input logic [127:0] st, input logic inv, input logic [127:0] exp);
        logic [127:0] res; int lat; bit hs; bit tmo;
        for (int u = 0; u < 3; u++) begin
            run_txn(u, st, inv, 2, res, lat, hs, tmo);
            total_cnt++;
            if (tmo) $display("FAIL %s u%0d: timeout waiting for handshake", name, u);
            else if (res !== exp) $display("FAIL %s u%0d: got %h required %h", name, u, res, exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != 4 / lanes_of[u]) $display("FAIL %s_latency u%0d: got %0d required %0d", name, u, lat, 4 / lanes_of[u]);
            else pass_cnt++;
            total_cnt++;
            if (!hs) $display("FAIL %s_handshake u%0d: hold/pop behaviour wrong", name, u);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp; int w;
        exp = {4{32'h8e4da1bc}};
        w = 0;
        @(negedge clk);
        in_valid[0] = 1'b1; in_state[0] = {4{32'hdb135345}}; in_inv[0] = 1'b0;
        @(posedge clk); #1;
        in_state[0] = {4{32'h01234567}}; in_inv[0] = 1'b1;  // held valid but must be ignored
        while (!out_valid[0] && w < 50) begin @(posedge clk); #1; w++; end
        total_cnt++;
        if (out_valid[0] !== 1'b1) $display("FAIL bp_done: out_valid=%b required 1", out_valid[0]);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_state[0] !== exp || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1)
                $display("FAIL bp_hold%0d: os=%h ov=%b ir=%b busy=%b required %h 1 0 1", i, out_state[0], out_valid[0], in_ready[0], busy[0], exp);
            else pass_cnt++;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        total_cnt++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1)
            $display("FAIL bp_pop: ov=%b busy=%b ir=%b required 0 0 1", out_valid[0], busy[0], in_ready[0]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_valid[0] = 1'b1; in_state[0] = {4{32'hdb135345}}; in_inv[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;                // accept, cnt=0
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);         // cnt=2
        #1;
        total_cnt++;
        if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) $display("FAIL midrun_state: busy=%b ov=%b required 1 0", busy[0], out_valid[0]);
        else pass_cnt++;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_state[0] !== 128'h0)
            $display("FAIL midrun_reset: ov=%b busy=%b os=%h required 0 0 0", out_valid[0], busy[0], out_state[0]);
        else pass_cnt++;
        rst[0] = 1'b0;
        #1;
        total_cnt++;
        if (in_ready[0] !== 1'b1) $display("FAIL midrun_idle: in_ready=%b required 1", in_ready[0]);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid[0] !== 1'b0 || out_state[0] !== 128'h0)
                $display("FAIL midrun_discard%0d: ov=%b os=%h required 0 0", i, out_valid[0], out_state[0]);
            else pass_cnt++;
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] x; logic [127:0] y; logic [127:0] z; logic m;
        int lat; bit hs; bit tmo; int u;
        for (int i = 0; i < 1000; i++) begin
            u = i % 3;
            x = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            run_txn(u, x, m, $urandom_range(0, 3), y, lat, hs, tmo);
            total_cnt++;
            if (tmo || !hs || lat != 4 / lanes_of[u] || y !== model(x, m))
                $display("FAIL rand%0d_first u%0d: got %h lat %0d hs %b tmo %b required %h lat %0d", i, u, y, lat, hs, tmo, model(x, m), 4 / lanes_of[u]);
            else pass_cnt++;
            run_txn(u, y, ~m, $urandom_range(0, 3), z, lat, hs, tmo);
            total_cnt++;
            if (tmo || !hs || z !== x)
                $display("FAIL rand%0d_roundtrip u%0d: got %h hs %b tmo %b required %h", i, u, z, hs, tmo, x);
            else pass_cnt++;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; in_valid[u] = 1'b0; in_state[u] = '0; in_inv[u] = 1'b0; out_ready[u] = 1'b0;
        end
        test_reset();
        test_vector("fwd_col", {4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        test_vector("inv_col", 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1,
                    128'hdb135345_f20a225c_01010101_2d26314c);
        test_vector("fwd_state", 128'hd4d4d4d5_2d26314c_c6c6c6c6_f20a225c, 1'b0,
                    128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_9fdc589d);
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
